// File: rtl/noc_router_xy_sync.sv
// Clocked 5-port mesh/torus router: per-input FIFOs, X-then-Y routing,
// per-output round-robin arbitration into a 1-entry output register.
module noc_router_xy_sync #(
  parameter int DATA_WIDTH = 33,
  parameter int ADDR_WIDTH = 4,
  parameter int MESH_X     = 5,
  parameter int MESH_Y     = 3,
  parameter int X_ID       = 1,
  parameter int Y_ID       = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int WRAP       = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4:0]              in_valid,
  input  logic [5*DATA_WIDTH-1:0] in_data,
  output logic [4:0]              in_ready,
  output logic [4:0]              out_valid,
  output logic [5*DATA_WIDTH-1:0] out_data,
  input  logic [4:0]              out_ready,
  output logic                    drop_pulse,
  output logic [15:0]             drop_cnt
);
  localparam int NP    = 5;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [2:0] P_PE = 3'd0, P_LEFT = 3'd1, P_RIGHT = 3'd2, P_UP = 3'd3, P_DOWN = 3'd4;

  function automatic logic [2:0] inc_port(input logic [2:0] p);
    return (p == 3'd4) ? 3'd0 : p + 3'd1;
  endfunction

  function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] id);
    int id_v;
    id_v = int'(id);
    return id_v >= MESH_X * MESH_Y;
  endfunction

  // Torus: positive direction when the forward hop count is at most half the ring (ties go positive).
  function automatic logic [2:0] route_port(input logic [ADDR_WIDTH-1:0] id);
    int id_v, xd, yd, dx, dy;
    logic [2:0] port;
    id_v = int'(id);
    xd   = id_v % MESH_X;
    yd   = id_v / MESH_X;
    dx   = xd - X_ID;
    dy   = yd - Y_ID;
    port = P_PE;
    if (dx != 0) begin
      if (WRAP != 0) port = (((dx + MESH_X) % MESH_X) <= MESH_X / 2) ? P_RIGHT : P_LEFT;
      else           port = (dx > 0) ? P_RIGHT : P_LEFT;
    end else if (dy != 0) begin
      if (WRAP != 0) port = (((dy + MESH_Y) % MESH_Y) <= MESH_Y / 2) ? P_DOWN : P_UP;
      else           port = (dy > 0) ? P_DOWN : P_UP;
    end
    return port;
  endfunction

  logic [NP-1:0][DATA_WIDTH-1:0] head_p0;
  logic [NP-1:0][2:0]            route_p0;
  logic [NP-1:0]                 bad_p0;
  logic [NP-1:0]                 empty_p0;
  logic [NP-1:0]                 drop_p0;
  logic [NP-1:0]                 pop_p0;
  logic [NP-1:0][NP-1:0]         req_p0;
  logic [NP-1:0][NP-1:0]         gnt_oh_p0;

  // Stage p0: input FIFOs and head-of-line routing
  for (genvar p = 0; p < NP; p++) begin : g_fifo
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        count;
    logic                  push;

    assign in_ready[p]  = (count != FULL_CNT);
    assign push         = in_valid[p] && in_ready[p];
    assign empty_p0[p]  = (count == '0);
    assign head_p0[p]   = mem[rd_ptr];
    assign bad_p0[p]    = addr_bad(head_p0[p][DATA_WIDTH-1 -: ADDR_WIDTH]);
    assign route_p0[p]  = route_port(head_p0[p][DATA_WIDTH-1 -: ADDR_WIDTH]);
    assign drop_p0[p]   = !empty_p0[p] && bad_p0[p];

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data[p*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)      wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_p0[p]) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop_p0[p]})
          2'b10:   count <= count + (PTR_W+1)'(1);
          2'b01:   count <= count - (PTR_W+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_comb begin
    pop_p0 = drop_p0;
    for (int o = 0; o < NP; o++) pop_p0 = pop_p0 | gnt_oh_p0[o];
  end

  // Stage p1: per-output round-robin arbitration and output registers
  for (genvar o = 0; o < NP; o++) begin : g_out
    logic [2:0]            ptr;
    logic [2:0]            gnt;
    logic                  gnt_vld;
    logic                  load;
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;

    for (genvar p = 0; p < NP; p++) begin : g_req
      assign req_p0[o][p] = !empty_p0[p] && !bad_p0[p] && (route_p0[p] == 3'(o));
    end

    assign load = !vld_p1 || out_ready[o];

    always_comb begin
      logic [2:0] cand;
      gnt_vld = 1'b0;
      gnt     = ptr;
      cand    = ptr;
      for (int k = 0; k < NP; k++) begin
        if (!gnt_vld && req_p0[o][cand]) begin
          gnt_vld = 1'b1;
          gnt     = cand;
        end
        cand = inc_port(cand);
      end
    end

    assign gnt_oh_p0[o] = (load && gnt_vld) ? (5'b00001 << gnt) : 5'b00000;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ptr     <= 3'd0;
        vld_p1  <= 1'b0;
        data_p1 <= '0;
      end else if (load) begin
        if (gnt_vld) begin
          vld_p1  <= 1'b1;
          data_p1 <= head_p0[gnt];
          ptr     <= inc_port(gnt);
        end else begin
          vld_p1  <= 1'b0;
        end
      end
    end

    assign out_valid[o]                        = vld_p1;
    assign out_data[o*DATA_WIDTH +: DATA_WIDTH] = data_p1;
  end

  logic [2:0]  n_drop;
  logic [16:0] drop_sum;

  always_comb begin
    n_drop = 3'd0;
    for (int p = 0; p < NP; p++) n_drop = n_drop + {2'b00, drop_p0[p]};
    drop_sum = {1'b0, drop_cnt} + {14'b0, n_drop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_pulse <= 1'b0;
      drop_cnt   <= 16'h0000;
    end else begin
      drop_pulse <= |drop_p0;
      drop_cnt   <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
endmodule
